// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: a shadow scoreboard of the
// EX/MEM/WB destinations drives RAW stalls, taken-branch flushes and EX operand selects.
module pipe_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int FORWARD      = 1,
    parameter int BRANCH_STAGE = 3,
    parameter int RF_BYPASS    = 0,
    parameter int CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_dest_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              flush_exmem_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam bit         USE_FWD   = (FORWARD != 0);
    localparam bit         FLUSH_MEM = (BRANCH_STAGE == 3);
    localparam bit         WB_HAZARD = (RF_BYPASS == 0);

    function automatic logic slot_match(input logic              vld,
                                        input logic              rw,
                                        input logic [REG_AW-1:0] dest,
                                        input logic [REG_AW-1:0] src,
                                        input logic              src_used);
        return vld && rw && (dest != '0) && (dest == src) && src_used;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        if (en && (cnt != '1))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // Nearest producer wins: the instruction currently in EX is younger than the one in MEM.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        if (mem_hit)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

    // Scoreboard slots: p0 = EX, p1 = MEM, p2 = WB
    logic              vld_p0, vld_p1, vld_p2;
    logic              rw_p0, rw_p1, rw_p2;
    logic              ld_p0;
    logic [REG_AW-1:0] dest_p0, dest_p1, dest_p2;

    logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
    logic raw_hit, flush, stall, load_ex, kill_mem;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    assign ex_rs  = slot_match(vld_p0, rw_p0, dest_p0, id_rs_i, id_use_rs_i);
    assign ex_rt  = slot_match(vld_p0, rw_p0, dest_p0, id_rt_i, id_use_rt_i);
    assign mem_rs = slot_match(vld_p1, rw_p1, dest_p1, id_rs_i, id_use_rs_i);
    assign mem_rt = slot_match(vld_p1, rw_p1, dest_p1, id_rt_i, id_use_rt_i);
    assign wb_rs  = slot_match(vld_p2, rw_p2, dest_p2, id_rs_i, id_use_rs_i);
    assign wb_rt  = slot_match(vld_p2, rw_p2, dest_p2, id_rt_i, id_use_rt_i);

    always_comb begin
        raw_hit = 1'b0;
        if (USE_FWD)
            raw_hit = (ex_rs | ex_rt) & ld_p0;
        else
            raw_hit = ex_rs | ex_rt | mem_rs | mem_rt | (WB_HAZARD & (wb_rs | wb_rt));
    end

    // A taken branch squashes the stalled consumer anyway, so flush overrides stall.
    assign flush    = branch_taken_i & ~rst_i;
    assign stall    = id_valid_i & ~rst_i & ~flush & raw_hit;
    assign load_ex  = id_valid_i & ~flush & ~stall;
    assign kill_mem = flush & FLUSH_MEM;

    assign pc_write_o    = ~stall;
    assign ifid_write_o  = ~stall;
    assign flush_ifid_o  = flush;
    assign flush_idex_o  = flush | stall;
    assign flush_exmem_o = kill_mem;

    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (USE_FWD && load_ex) begin
            fwd_a_nxt = fwd_sel(ex_rs, mem_rs);
            fwd_b_nxt = fwd_sel(ex_rt, mem_rt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0      <= 1'b0;
            rw_p0       <= 1'b0;
            ld_p0       <= 1'b0;
            vld_p1      <= 1'b0;
            rw_p1       <= 1'b0;
            vld_p2      <= 1'b0;
            rw_p2       <= 1'b0;
            fwd_a_o     <= FWD_RF;
            fwd_b_o     <= FWD_RF;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            // ID -> EX
            vld_p0  <= load_ex;
            rw_p0   <= load_ex & id_regwrite_i;
            ld_p0   <= load_ex & id_memread_i;
            fwd_a_o <= fwd_a_nxt;
            fwd_b_o <= fwd_b_nxt;
            // EX -> MEM
            vld_p1  <= vld_p0 & ~kill_mem;
            rw_p1   <= rw_p0 & ~kill_mem;
            // MEM -> WB
            vld_p2  <= vld_p1;
            rw_p2   <= rw_p1;
            stall_cnt_o <= sat_inc(stall_cnt_o, stall);
            flush_cnt_o <= sat_inc(flush_cnt_o, flush);
        end
    end

    // Destination fields are qualified by the slot valid bits, so they need no reset.
    always_ff @(posedge clk_i) begin
        dest_p0 <= load_ex ? id_dest_i : '0;
        dest_p1 <= kill_mem ? '0 : dest_p0;
        dest_p2 <= dest_p1;
    end

endmodule
